// File: rtl/serial_sub4_if.sv
// serial_sub4_if: operand/request and result bundle for the bit-serial subtractor.
// ovf is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, x, y, b_in,
    input  busy, done, diff, b_out
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, x, y, b_in,
    output busy, done, diff, b_out
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial x - y - b_in, one full-subtractor cell plus borrow FF; SERIAL_SUB_OVF_EN adds signed overflow flag ovf.
// Latency: WIDTH cycles from accepted start to done pulse; back-to-back throughput one op per WIDTH+1 cycles.
// Backpressure: start is sampled only when busy is low (IDLE or the DONE cycle); requests during SHIFT are dropped.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub4_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             b_out_q;
  logic             load;
  logic             last;
  logic             a;
  logic             b;
  logic             d;
  logic             br_nxt;

  assign a      = x_sr[0];
  assign b      = y_sr[0];
  assign d      = a ^ b ^ br;
  assign br_nxt = (~a & b) | (~(a ^ b) & br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // DONE doubles as an accept slot so back-to-back ops lose only one cycle
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sr    <= '0;
      y_sr    <= '0;
      d_sr    <= '0;
      cnt     <= '0;
      br      <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else if (load) begin
      x_sr <= bus.x;
      y_sr <= bus.y;
      d_sr <= '0;
      br   <= bus.b_in;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      x_sr <= x_sr >> 1;
      y_sr <= y_sr >> 1;
      d_sr <= {d, d_sr[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      // Result registers only move on the final bit, so a partial result is never visible
      if (last) begin
        diff_q  <= {d, d_sr[WIDTH-1:1]};
        b_out_q <= br_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic x_msb;
  logic y_msb;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      x_msb <= bus.x[WIDTH-1];
      y_msb <= bus.y[WIDTH-1];
    end else if (last) begin
      // The final serial bit is the MSB of the difference
      ovf_q <= (x_msb != y_msb) && (d != x_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: directed plus random checks of serial_sub4 against an arithmetic timeline model.
// SERIAL_SUB_OVF_EN selects the overflow-flag checks as well.
module tb_serial_sub4;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;

  serial_sub4_if #(.WIDTH(W)) bus ();
  serial_sub4 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request becomes a pending result that lands W cycles later
  logic         m_busy, m_done, m_bout, p_bout, m_ovf, p_ovf;
  logic [W-1:0] m_diff, p_diff;
  int           m_rem;
  int           t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_bout <= 1'b0; m_ovf <= 1'b0;
      m_diff <= '0;   m_rem  <= 0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_diff <= p_diff; m_bout <= p_bout; m_ovf <= p_ovf;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        t = int'(bus.x) - int'(bus.y) - int'(bus.b_in);
        p_diff = W'(t);
        p_bout = (t < 0);
        p_ovf  = (bus.x[W-1] != bus.y[W-1]) && (p_diff[W-1] != bus.x[W-1]);
        m_busy <= 1'b1;
        m_rem  <= W;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, m_done);
    chk("diff", bus.diff, m_diff);
    chk("b_out", bus.b_out, m_bout);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", bus.ovf, m_ovf);
`endif
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.x = xv; bus.y = yv; bus.b_in = bv;
    @(negedge clk);
    bus.start = 1'b0; bus.x = W'($urandom); bus.y = W'($urandom); bus.b_in = 1'($urandom);
    wait_done(lat);
  endtask

  int lat;
  int d0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.b_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_diff", bus.diff, 4'b0000);
    chk("rst_bout", bus.b_out, 1'b0);
    #3 rst = 1'b0;

    op(4'b0101, 4'b0011, 1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_diff", bus.diff, 4'b0010);
    chk("t1_bout", bus.b_out, 1'b0);

    op(4'b0011, 4'b0101, 1'b0, lat);
    chk("t2_diff", bus.diff, 4'b1110);
    chk("t2_bout", bus.b_out, 1'b1);
    op(4'b0000, 4'b0000, 1'b1, lat);
    chk("t3_diff", bus.diff, 4'b1111);
    chk("t3_bout", bus.b_out, 1'b1);

    // start held high: second op is accepted in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.x = 4'b1111; bus.y = 4'b1111; bus.b_in = 1'b0;
    @(negedge clk);
    bus.x = 4'b0101; bus.y = 4'b0011;
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_diff1", bus.diff, 4'b0000);
    chk("b2b_bout1", bus.b_out, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== 1'b1 && lat < 20);
    bus.start = 1'b0;
    chk("b2b_gap", 32'(lat), 32'd5);
    chk("b2b_diff2", bus.diff, 4'b0010);

    // start during SHIFT is dropped
    @(negedge clk); #1 d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 4'b1000; bus.y = 4'b0001; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 4'b0000; bus.y = 4'b1111;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("ign_diff", bus.diff, 4'b0111);
    chk("ign_bout", bus.b_out, 1'b0);
    repeat (6) @(negedge clk);
    #1 chk("ign_done_count", 32'(done_cnt - d0), 32'd1);

    // mid-operation reset
    @(negedge clk);
    bus.start = 1'b1; bus.x = 4'b0101; bus.y = 4'b0011;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_diff", bus.diff, 4'b0000);
    chk("abort_bout", bus.b_out, 1'b0);
    @(negedge clk); #3 rst = 1'b0;
    #1 d0 = done_cnt;
    repeat (8) @(negedge clk);
    #1 chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    op(4'b0111, 4'b1000, 1'b0, lat);
    chk("ovf1_diff", bus.diff, 4'b1111);
    chk("ovf1_ovf", bus.ovf, 1'b1);
    op(4'b0101, 4'b0011, 1'b0, lat);
    chk("ovf0_ovf", bus.ovf, 1'b0);
`endif

    repeat (400) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.x     = W'($urandom);
      bus.y     = W'($urandom);
      bus.b_in  = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
